// File: rtl/spi_mem_arbiter.sv
// Round-robin sequencer sharing one SPI SRAM master between fetch and data ports.
// Define SPI_ARB_TIMEOUT_EN to add a per-transaction watchdog that aborts with d_err.
module spi_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter int unsigned RECOVER_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [23:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [23:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   output logic        spi_req,
   output logic [23:0] spi_addr,
   output logic [31:0] spi_wdata,
   output logic [1:0]  spi_byte_mask,
   output logic        spi_write,
   input  logic        spi_busy,
   input  logic        spi_valid,
   input  logic [31:0] spi_rdata
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, RECOVER} state_t;

   localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;   // 1 = data port
   logic        owner_q, owner_d;             // 1 = data port
   logic [23:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  mask_q, mask_d;
   logic        write_q, write_d;
   logic [31:0] rdata_q, rdata_d;
   logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
   logic        grant_data;
   logic        err_flag;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             err_q, err_d;
   assign err_flag = err_q;
`else
   assign err_flag = 1'b0;
`endif

   // Master returns data MSB-aligned; requesters want it right-justified.
   function automatic logic [31:0] align_rd(input logic [1:0] mask, input logic [31:0] data);
      case (mask)
         2'b00:   align_rd = {24'h0, data[31:24]};
         2'b01:   align_rd = {16'h0, data[31:16]};
         default: align_rd = data;
      endcase
   endfunction

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      write_d      = write_q;
      rdata_d      = rdata_q;
      rec_cnt_d    = rec_cnt_q;
      grant_data   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      err_d        = err_q;
`endif
      case (state_q)
         IDLE: begin
            if ((if_req || d_req) && !spi_busy) begin
               // Data wins a tie unless it was the previous owner.
               grant_data   = d_req && (!if_req || !last_grant_q);
               owner_d      = grant_data;
               last_grant_d = grant_data;
               rdata_d      = 32'h0;
               state_d      = RUN;
`ifdef SPI_ARB_TIMEOUT_EN
               tmo_cnt_d    = '0;
               err_d        = 1'b0;
`endif
               if (grant_data) begin
                  addr_d  = d_addr;
                  write_d = d_we;
                  case (d_size)
                     2'b00: begin
                        mask_d  = 2'b00;
                        wdata_d = {d_wdata[7:0], 24'h0};
                     end
                     2'b01: begin
                        mask_d  = 2'b01;
                        wdata_d = {d_wdata[15:0], 16'h0};
                     end
                     default: begin
                        mask_d  = 2'b10;
                        wdata_d = d_wdata;
                     end
                  endcase
               end else begin
                  addr_d  = if_addr;
                  write_d = 1'b0;
                  mask_d  = 2'b10;
                  wdata_d = 32'h0;
               end
            end
         end
         RUN: begin
            if (spi_valid) begin
               rdata_d = write_q ? 32'h0 : align_rd(mask_q, spi_rdata);
               state_d = DONE;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            rec_cnt_d = '0;
            state_d   = RECOVER;
         end
         default: begin
            if (rec_cnt_q == REC_W'(RECOVER_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               rec_cnt_d = rec_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b0;
         owner_q      <= 1'b0;
         addr_q       <= 24'h0;
         wdata_q      <= 32'h0;
         mask_q       <= 2'b00;
         write_q      <= 1'b0;
         rdata_q      <= 32'h0;
         rec_cnt_q    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         write_q      <= write_d;
         rdata_q      <= rdata_d;
         rec_cnt_q    <= rec_cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   assign spi_req       = (state_q != RUN);
   assign spi_addr      = addr_q;
   assign spi_wdata     = wdata_q;
   assign spi_byte_mask = mask_q;
   assign spi_write     = write_q;
   assign if_ack        = (state_q == DONE) && !owner_q;
   assign d_ack         = (state_q == DONE) && owner_q;
   assign if_rdata      = if_ack ? rdata_q : 32'h0;
   assign d_rdata       = d_ack ? rdata_q : 32'h0;
   assign d_err         = d_ack && err_flag;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: reset, fetch, data alignment table,
// round-robin contention, mid-transaction reset and (optionally) the watchdog.
module tb_spi_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [23:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic [23:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        d_err;
   logic        spi_req;
   logic [23:0] spi_addr;
   logic [31:0] spi_wdata;
   logic [1:0]  spi_byte_mask;
   logic        spi_write;
   logic        spi_busy;
   logic        spi_valid;
   logic [31:0] spi_rdata;

   int checks = 0;
   int errors = 0;

   spi_mem_arbiter #(
      .TIMEOUT_CYCLES(16),
      .RECOVER_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .spi_req(spi_req), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_byte_mask(spi_byte_mask), .spi_write(spi_write), .spi_busy(spi_busy),
      .spi_valid(spi_valid), .spi_rdata(spi_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      logic [31:0] exp_wdata;
      logic [1:0]  exp_mask;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance negedges until the master is told to run; n counts cycles waited.
   task automatic wait_run(input string name, output int n);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n++;
         if (!spi_req) break;
      end
      check({name, "_run_reached"}, {31'h0, ~spi_req}, 32'h1);
   endtask

   task automatic pulse_valid(input logic [31:0] d);
      spi_valid = 1'b1;
      spi_rdata = d;
      @(negedge clk);
      spi_valid = 1'b0;
      spi_rdata = 32'h0;
   endtask

   task automatic run_data(input vec_t v, input int delay, input string name);
      int n;
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
      wait_run(name, n);
      check({name, "_addr"}, {8'h0, spi_addr}, {8'h0, v.addr});
      check({name, "_write"}, {31'h0, spi_write}, {31'h0, v.we});
      check({name, "_mask"}, {30'h0, spi_byte_mask}, {30'h0, v.exp_mask});
      if (v.we) check({name, "_wdata"}, spi_wdata, v.exp_wdata);
      repeat (delay) @(negedge clk);
      check({name, "_hold_req"}, {31'h0, spi_req}, 32'h0);
      pulse_valid(v.mrd);
      check({name, "_ack"}, {31'h0, d_ack}, 32'h1);
      check({name, "_rdata"}, d_rdata, v.exp_rdata);
      check({name, "_err"}, {31'h0, d_err}, 32'h0);
      check({name, "_if_ack"}, {31'h0, if_ack}, 32'h0);
      check({name, "_req_in_ack"}, {31'h0, spi_req}, 32'h1);
      $display("txn %s: we=%0d size=%0d addr=0x%06h d_rdata=0x%08h", name, v.we, v.size, v.addr, d_rdata);
      d_req = 1'b0;
      @(negedge clk);
      check({name, "_ack_drop"}, {31'h0, d_ack}, 32'h0);
      check({name, "_rdata_zero"}, d_rdata, 32'h0);
   endtask

   initial begin
      int n;
      vecs[0] = '{1'b1, 2'd0, 24'h000203, 32'h000000A5, 32'hFFFFFFFF, 32'hA5000000, 2'b00, 32'h0};
      vecs[1] = '{1'b0, 2'd1, 24'h000400, 32'h0, 32'h12345678, 32'h0, 2'b01, 32'h00001234};
      vecs[2] = '{1'b0, 2'd0, 24'h000401, 32'h0, 32'h9ABCDEF0, 32'h0, 2'b00, 32'h0000009A};
      vecs[3] = '{1'b0, 2'd2, 24'h000404, 32'h0, 32'h89ABCDEF, 32'h0, 2'b10, 32'h89ABCDEF};
      vecs[4] = '{1'b0, 2'd3, 24'h000408, 32'h0, 32'h01020304, 32'h0, 2'b10, 32'h01020304};
      vecs[5] = '{1'b1, 2'd1, 24'h000502, 32'hFFFFBEEF, 32'h55555555, 32'hBEEF0000, 2'b01, 32'h0};
      vecs[6] = '{1'b1, 2'd2, 24'h000504, 32'h11223344, 32'hAAAAAAAA, 32'h11223344, 2'b10, 32'h0};

      reset = 1'b0; if_req = 1'b0; if_addr = 24'h0; d_req = 1'b0; d_we = 1'b0;
      d_size = 2'd0; d_addr = 24'h0; d_wdata = 32'h0;
      spi_busy = 1'b0; spi_valid = 1'b0; spi_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_spi_req", {31'h0, spi_req}, 32'h1);
      check("rst_acks", {30'h0, if_ack, d_ack}, 32'h0);
      check("rst_err", {31'h0, d_err}, 32'h0);
      check("rst_rdata", if_rdata | d_rdata, 32'h0);
      check("rst_fields", {6'h0, spi_write, spi_byte_mask, spi_addr[22:0]}, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Tie right after reset: data first, then fetch.
      if_req = 1'b1; if_addr = 24'h000800;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 24'h000600;
      wait_run("tie1", n);
      check("tie1_first_grant_latency", n, 1);
      check("tie1_addr_is_data", {8'h0, spi_addr}, 32'h00000600);
      pulse_valid(32'hCAFEF00D);
      check("tie1_d_ack", {31'h0, d_ack}, 32'h1);
      check("tie1_if_ack", {31'h0, if_ack}, 32'h0);
      check("tie1_rdata", d_rdata, 32'hCAFEF00D);
      $display("txn tie data: addr=0x000600 d_rdata=0x%08h", d_rdata);
      d_req = 1'b0;
      wait_run("tie2", n);
      check("tie_gap_ge_recover", {31'h0, n >= 3}, 32'h1);
      check("tie2_addr_is_fetch", {8'h0, spi_addr}, 32'h00000800);
      pulse_valid(32'h0BADF00D);
      check("tie2_if_ack", {31'h0, if_ack}, 32'h1);
      check("tie2_if_rdata", if_rdata, 32'h0BADF00D);
      $display("txn tie fetch: addr=0x000800 if_rdata=0x%08h", if_rdata);
      if_req = 1'b0;
      @(negedge clk);
      check("tie2_ack_drop", {31'h0, if_ack}, 32'h0);

      // Plain fetch.
      if_req = 1'b1; if_addr = 24'h000100;
      wait_run("fetch", n);
      check("fetch_mask", {30'h0, spi_byte_mask}, 32'h2);
      check("fetch_write", {31'h0, spi_write}, 32'h0);
      check("fetch_addr", {8'h0, spi_addr}, 32'h00000100);
      repeat (2) @(negedge clk);
      check("fetch_no_early_ack", {31'h0, if_ack}, 32'h0);
      pulse_valid(32'hDEADBEEF);
      check("fetch_ack", {31'h0, if_ack}, 32'h1);
      check("fetch_rdata", if_rdata, 32'hDEADBEEF);
      $display("txn fetch: addr=0x000100 if_rdata=0x%08h", if_rdata);
      if_req = 1'b0;
      @(negedge clk);
      check("fetch_single_pulse", {31'h0, if_ack}, 32'h0);
      check("fetch_rdata_zero", if_rdata, 32'h0);

      for (int i = 0; i < 7; i++) begin
         run_data(vecs[i], i % 3, $sformatf("vec%0d", i));
      end

      // Reset in RUN aborts with no ack.
      d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 24'h000700;
      wait_run("abort", n);
      reset = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("abort_spi_req", {31'h0, spi_req}, 32'h1);
      check("abort_no_ack", {30'h0, if_ack, d_ack}, 32'h0);
      reset = 1'b1;
      spi_valid = 1'b1; spi_rdata = 32'h77777777;
      @(negedge clk);
      spi_valid = 1'b0; spi_rdata = 32'h0;
      @(negedge clk);
      check("abort_still_no_ack", {30'h0, if_ack, d_ack}, 32'h0);
      check("abort_idle", {31'h0, spi_req}, 32'h1);
      $display("txn abort: reset during RUN, spi_req=%0d", spi_req);

`ifdef SPI_ARB_TIMEOUT_EN
      begin
         int run_cycles;
         logic got_ack;
         d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = 24'h000900;
         wait_run("tmo", n);
         run_cycles = 1;
         got_ack = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_ack) begin
               got_ack = 1'b1;
               break;
            end
            if (!spi_req) run_cycles++;
         end
         check("tmo_ack_seen", {31'h0, got_ack}, 32'h1);
         check("tmo_run_cycles", run_cycles, 16);
         check("tmo_err", {31'h0, d_err}, 32'h1);
         check("tmo_rdata", d_rdata, 32'h0);
         check("tmo_spi_req", {31'h0, spi_req}, 32'h1);
         $display("txn timeout: run_cycles=%0d d_err=%0d", run_cycles, d_err);
         d_req = 1'b0;
         @(negedge clk);
         check("tmo_err_drop", {31'h0, d_err}, 32'h0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
